// File: rtl/simon_arb_pkg.sv
// Shared types, widths and the round-robin pick function for the simon core arbiter.
package simon_arb_pkg;

  localparam int SIMON_N = 32;
  localparam int SIMON_M = 4;
  localparam int BLK     = 2 * SIMON_N;
  localparam int KEYW    = SIMON_N * SIMON_M;
  localparam int MAX_REQ = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CRST  = 3'd1,
    ST_START = 3'd2,
    ST_BUSY  = 3'd3,
    ST_RESP  = 3'd4
  } arb_state_e;

  // First valid requester at or after ptr, scanning upward with wrap over nreq slots.
  function automatic logic [1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                         input logic [1:0] ptr,
                                         input int nreq);
    logic [1:0] pick;
    int         idx;
    pick = ptr;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      if (k < nreq) begin
        idx = (int'(ptr) + k) % nreq;
        if (valid[idx]) pick = idx[1:0];
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/simon_rr_arbiter.sv
// Combinational round-robin picker with a registered priority pointer.
module simon_rr_arbiter
  import simon_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDXW = 1
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic [NREQ-1:0] req_valid_i,
  input  logic            adv_i,
  input  logic [IDXW-1:0] adv_idx_i,
  output logic            any_o,
  output logic [IDXW-1:0] grant_idx_o,
  output logic [IDXW-1:0] ptr_o
);

  logic [IDXW-1:0]    ptr_q, ptr_d;
  logic [MAX_REQ-1:0] valid_pad;
  logic [1:0]         pick;

  assign valid_pad   = MAX_REQ'(req_valid_i);
  assign pick        = rr_pick(valid_pad, 2'(ptr_q), NREQ);
  assign grant_idx_o = IDXW'(pick);
  assign any_o       = |req_valid_i;
  assign ptr_o       = ptr_q;

  // The requester just served drops to lowest priority.
  always_comb begin
    ptr_d = ptr_q;
    if (adv_i) ptr_d = IDXW'((int'(adv_idx_i) + 1) % NREQ);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end

endmodule

// File: rtl/simon_core_arbiter.sv
// Sequences one shared simon core (reset, start, wait done) for NREQ requesters with
// per-requester ciphertext chaining and a BUSY timeout that returns an error response.
module simon_core_arbiter
  import simon_arb_pkg::*;
#(
  parameter int N       = SIMON_N,
  parameter int M       = SIMON_M,
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ-1:0]      req_chain,
  input  logic [NREQ*N*M-1:0]  req_key,
  input  logic [NREQ*2*N-1:0]  req_pt,
  output logic [NREQ-1:0]      resp_valid,
  input  logic [NREQ-1:0]      resp_ready,
  output logic [2*N-1:0]       resp_ct,
  output logic                 resp_err,
  output logic                 core_rst,
  output logic                 core_en,
  output logic [N*M-1:0]       core_key,
  output logic [2*N-1:0]       core_pt,
  input  logic [2*N-1:0]       core_ct,
  input  logic                 core_done,
  output arb_state_e           dbg_state_o
);

  localparam int BLK_W = 2 * N;
  localparam int KEY_W = N * M;
  localparam int IDXW  = (NREQ > 2) ? 2 : 1;
  localparam int CNTW  = $clog2(TIMEOUT + 1);

  // Handshakes: a request transfers on a cycle with req_valid[i] & req_ready[i]; a
  // response transfers on resp_valid[g] & resp_ready[g]. Valid never waits on ready.

  arb_state_e       state_q, state_d;
  logic [IDXW-1:0]  gnt_q, gnt_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [BLK_W-1:0] pt_q, pt_d;
  logic [BLK_W-1:0] ct_q, ct_d;
  logic             err_q, err_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [BLK_W-1:0] chain_q [NREQ];
  logic [BLK_W-1:0] chain_d [NREQ];
  logic             core_rst_q, core_en_q;

  logic [KEY_W-1:0] key_slot [NREQ];
  logic [BLK_W-1:0] pt_slot  [NREQ];
  logic             any_valid, advance;
  logic [IDXW-1:0]  pick_idx, rr_ptr;

  for (genvar i = 0; i < NREQ; i++) begin : g_slot
    assign key_slot[i] = req_key[i*KEY_W +: KEY_W];
    assign pt_slot[i]  = req_pt[i*BLK_W +: BLK_W];
  end

  simon_rr_arbiter #(.NREQ(NREQ), .IDXW(IDXW)) u_rr (
    .clk_i       (clk),
    .rst_n_i     (rst),
    .req_valid_i (req_valid),
    .adv_i       (advance),
    .adv_idx_i   (gnt_q),
    .any_o       (any_valid),
    .grant_idx_o (pick_idx),
    .ptr_o       (rr_ptr)
  );

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    key_d      = key_q;
    pt_d       = pt_q;
    ct_d       = ct_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    chain_d    = chain_q;
    advance    = 1'b0;
    req_ready  = '0;
    resp_valid = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (rst && any_valid) begin
          req_ready[pick_idx] = 1'b1;
          gnt_d   = pick_idx;
          key_d   = key_slot[pick_idx];
          pt_d    = req_chain[pick_idx] ? chain_q[pick_idx] : pt_slot[pick_idx];
          state_d = ST_CRST;
        end
      end
      ST_CRST:  state_d = ST_START;
      ST_START: begin
        cnt_d   = '0;
        state_d = ST_BUSY;
      end
      ST_BUSY: begin
        // done wins over a timeout landing on the same cycle
        if (core_done) begin
          ct_d           = core_ct;
          err_d          = 1'b0;
          chain_d[gnt_q] = core_ct;
          state_d        = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNTW'(TIMEOUT - 1)) begin
            ct_d    = '0;
            err_d   = 1'b1;
            state_d = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        resp_valid[gnt_q] = 1'b1;
        if (resp_ready[gnt_q]) begin
          advance = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      key_q      <= '0;
      pt_q       <= '0;
      ct_q       <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      core_rst_q <= 1'b1;
      core_en_q  <= 1'b0;
      for (int i = 0; i < NREQ; i++) chain_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      key_q      <= key_d;
      pt_q       <= pt_d;
      ct_q       <= ct_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      core_rst_q <= (state_d == ST_CRST);
      core_en_q  <= (state_d == ST_START);
      chain_q    <= chain_d;
    end
  end

  assign resp_ct     = ct_q;
  assign resp_err    = err_q;
  assign core_rst    = core_rst_q;
  assign core_en     = core_en_q;
  assign core_key    = key_q;
  assign core_pt     = pt_q;
  assign dbg_state_o = state_q;

endmodule
